// File: rtl/wb_queue_if.sv
// Writeback queue bundle: producer handshake, register-file write port and scoreboard lookup.
// The forwarding outputs exist only when WBQ_FORWARD_EN is defined.
interface wb_queue_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DEPTH         = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [ADDRESS_WIDTH-1:0] in_rd;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     port_busy;
  logic                     WE3;
  logic [ADDRESS_WIDTH-1:0] AD3;
  logic [DATA_WIDTH-1:0]    WD3;
  logic [ADDRESS_WIDTH-1:0] chk_addr1;
  logic [ADDRESS_WIDTH-1:0] chk_addr2;
  logic                     chk_busy1;
  logic                     chk_busy2;
  logic [CNT_W-1:0]         count;
  logic                     full;
  logic                     empty;
`ifdef WBQ_FORWARD_EN
  logic                     fwd_hit1;
  logic                     fwd_hit2;
  logic [DATA_WIDTH-1:0]    fwd_data1;
  logic [DATA_WIDTH-1:0]    fwd_data2;

  modport master (
    output in_valid, in_rd, in_data, port_busy, chk_addr1, chk_addr2,
    input  in_ready, WE3, AD3, WD3, chk_busy1, chk_busy2, count, full, empty,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
  modport slave (
    input  in_valid, in_rd, in_data, port_busy, chk_addr1, chk_addr2,
    output in_ready, WE3, AD3, WD3, chk_busy1, chk_busy2, count, full, empty,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
`else
  modport master (
    output in_valid, in_rd, in_data, port_busy, chk_addr1, chk_addr2,
    input  in_ready, WE3, AD3, WD3, chk_busy1, chk_busy2, count, full, empty
  );
  modport slave (
    input  in_valid, in_rd, in_data, port_busy, chk_addr1, chk_addr2,
    output in_ready, WE3, AD3, WD3, chk_busy1, chk_busy2, count, full, empty
  );
`endif
endinterface

// File: rtl/wb_queue.sv
// In-order writeback queue feeding the register file write port, with pending-write scoreboard.
// Optional WBQ_FORWARD_EN adds youngest-match data forwarding for the two source lookups.
module wb_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DEPTH         = 4
) (
  input logic     clk,
  input logic     rst,
  wb_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [CNT_W-1:0]         cnt;
  logic [DEPTH-1:0]         vld;
  logic [ADDRESS_WIDTH-1:0] rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];

  logic full, empty, enq, deq;
  logic busy1, busy2;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  // x0 results complete the handshake but are never stored
  assign enq   = bus.in_valid && !full && (bus.in_rd != '0);
  assign deq   = !empty && !bus.port_busy;

  assign bus.in_ready = !full;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = cnt;
  assign bus.WE3      = deq;
  assign bus.AD3      = empty ? '0 : rd_q[head];
  assign bus.WD3      = empty ? '0 : data_q[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      vld  <= '0;
    end else begin
      if (enq) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PTR_W'(1);
      end
      if (deq) begin
        vld[head] <= 1'b0;
        head      <= head + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload carries no reset; valid bits gate every use of it
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_q[tail]   <= bus.in_rd;
      data_q[tail] <= bus.in_data;
    end
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (rd_q[i] == bus.chk_addr1)) busy1 = 1'b1;
      if (vld[i] && (rd_q[i] == bus.chk_addr2)) busy2 = 1'b1;
    end
  end

  assign bus.chk_busy1 = busy1 && (bus.chk_addr1 != '0);
  assign bus.chk_busy2 = busy2 && (bus.chk_addr2 != '0);

`ifdef WBQ_FORWARD_EN
  logic [PTR_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] fd1, fd2;

  // Walk oldest to youngest so the last match left standing is the youngest
  always_comb begin
    idx = head;
    fd1 = '0;
    fd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (vld[idx] && (rd_q[idx] == bus.chk_addr1)) fd1 = data_q[idx];
      if (vld[idx] && (rd_q[idx] == bus.chk_addr2)) fd2 = data_q[idx];
    end
  end

  assign bus.fwd_hit1  = bus.chk_busy1;
  assign bus.fwd_hit2  = bus.chk_busy2;
  assign bus.fwd_data1 = bus.chk_busy1 ? fd1 : '0;
  assign bus.fwd_data2 = bus.chk_busy2 ? fd2 : '0;
`endif

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Writeback buffer that drives the register file's single write port (WE3/AD3/WD3).
- Accepts results from execute/multi-cycle units through a valid/ready handshake and queues them in order.
- Issues at most one register write per cycle whenever the write port is not claimed by a higher-priority source.
- Reports which registers still have pending writes so decode can stall.

Parameters:
- DATA_WIDTH, 32, width of result data and WD3.
- ADDRESS_WIDTH, 5, width of register addresses.
- DEPTH, 4, number of queue entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a result.
- in_ready  output  1  queue can accept; equals !full.
- in_rd  input  ADDRESS_WIDTH  destination register.
- in_data  input  DATA_WIDTH  result value.
- port_busy  input  1  write port claimed by another source this cycle; no dequeue.
- WE3  output  1  register file write enable.
- AD3  output  ADDRESS_WIDTH  register file write address.
- WD3  output  DATA_WIDTH  register file write data.
- chk_addr1  input  ADDRESS_WIDTH  source register 1 to check.
- chk_addr2  input  ADDRESS_WIDTH  source register 2 to check.
- chk_busy1  output  1  valid entry targets chk_addr1.
- chk_busy2  output  1  valid entry targets chk_addr2.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (asynchronous, active-high):
  - head, tail and count clear to 0; all entry valid bits clear.
  - Outputs: WE3=0, AD3=0, WD3=0, empty=1, full=0, in_ready=1, chk_busy1/2=0.
- Reset mid-operation discards all queued entries immediately; no write is issued.
- Enqueue:
  - Occurs on a rising edge when in_valid && in_ready.
  - {in_rd, in_data} is stored at tail; tail advances modulo DEPTH.
- Writes to x0 (in_rd == 0):
  - Handshake completes, but nothing is stored.
  - count is unchanged and the entry never appears on WE3.
- Write port outputs (combinational from the head entry):
  - WE3 = !empty && !port_busy.
  - AD3/WD3 show the head entry when !empty, otherwise 0.
- Dequeue:
  - Occurs on a rising edge when WE3 = 1; head advances modulo DEPTH.
  - The register file captures the write on that same edge.
- Latency: an entry enqueued at edge N appears on WE3 in cycle N+1, earliest written at edge N+1.
- Ordering: strict FIFO; two results to the same rd are written in arrival order, so the last one wins.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Full:
  - in_ready = !full; it does not look ahead to a same-cycle dequeue.
  - When full, one bubble occurs before the next accept.
- port_busy held high: the queue fills to DEPTH and then holds; contents are preserved.
- Scoreboard:
  - chk_busyN = OR over valid entries of (entry.rd == chk_addrN).
  - chk_addrN == 0 always gives 0.
  - The head entry being written this cycle still counts as busy in that cycle.
  - Combinational from state and chk_addr only; it does not depend on in_valid.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits wide; count disambiguates full from empty.

Optional Feature:
- Macro name: WBQ_FORWARD_EN.
- When defined, the block adds four outputs:
  - fwd_hit1/fwd_hit2, 1 bit each.
  - fwd_data1/fwd_data2, DATA_WIDTH each.
- fwd_hitN equals chk_busyN.
- fwd_dataN is the data of the youngest valid entry whose rd matches chk_addrN.
  - Youngest is the entry closest to tail.
  - fwd_dataN is 0 when there is no hit.
- Decode uses these to bypass queued results instead of stalling.
- Without the macro, these ports do not exist and only chk_busy is provided.

Test Plan:
- Reset, then in_valid=1, rd=5, data=0xDEADBEEF for one cycle, port_busy=0:
  - Next cycle WE3=1, AD3=5, WD3=0xDEADBEEF.
  - Following cycle empty=1, WE3=0.
- port_busy=1 with 5 enqueues (rd 1..5):
  - After 4 enqueues full=1 and in_ready=0; rd 5 is not accepted.
  - After port_busy=0, writes appear in order rd 1,2,3,4 on consecutive cycles, then rd 5 once accepted.
- Enqueue rd=0, data=0x1234:
  - in_ready=1, count stays 0, WE3 never asserts.
- port_busy=1, enqueue rd=7 data=0xA then rd=7 data=0xB, chk_addr1=7, chk_addr2=0:
  - chk_busy1=1, chk_busy2=0.
  - With WBQ_FORWARD_EN, fwd_data1=0xB.
  - After drain, chk_busy1=0.
- Wrap-around: stream 12 results (rd=i%31+1, data=i) with port_busy toggling every other cycle:
  - All 12 writes are observed in order with no loss or duplication; count never exceeds 4.
- Assert rst while count=3:
  - Same cycle WE3=0, empty=1, count=0.
  - After release, no stale entry is written.
